// File: rtl/rgmii_rx_dly_cal_if.sv
// Handshake/status bundle between the GMII receive side and the RX delay calibrator.
interface rgmii_rx_dly_cal_if;
    logic       gmii_rx_dv;
    logic [7:0] gmii_rxd;
    logic       cal_start;
    logic [4:0] in_dly;
    logic       indly_en;
    logic       cal_busy;
    logic       cal_done;
    logic       cal_fail;
    logic [4:0] win_lo;
    logic [4:0] win_hi;

    modport master (
        output gmii_rx_dv, gmii_rxd, cal_start,
        input  in_dly, indly_en, cal_busy, cal_done,
        input  cal_fail, win_lo, win_hi
    );

    modport slave (
        input  gmii_rx_dv, gmii_rxd, cal_start,
        output in_dly, indly_en, cal_busy, cal_done,
        output cal_fail, win_lo, win_hi
    );
endinterface

// File: rtl/rgmii_rx_dly_cal.sv
// RGMII RX IDELAY tap sweep: judges preamble/SFD per tap, programs the longest window centre.
// Define RGMII_RX_DLY_CAL_AUTO_START_EN to start one calibration right after reset release.
module rgmii_rx_dly_cal #(
    parameter int FRAMES_PER_TAP = 4,
    parameter int SETTLE_CYC     = 64,
    parameter int TIMEOUT_CYC    = 1000000,
    parameter int DEFAULT_TAP    = 0
) (
    input  logic                gmii_rx_clk,
    input  logic                rst_n,
    rgmii_rx_dly_cal_if.slave   bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_SET_TAP, S_SETTLE, S_HUNT,
        S_CHECK, S_NEXT, S_EVAL, S_DONE
    } state_t;

    localparam int SW = $clog2(SETTLE_CYC + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [7:0] PRE = 8'h55;
    localparam logic [7:0] SFD = 8'hD5;

    state_t          r_state, w_next;
    logic [4:0]      r_tap, r_in_dly, r_win_lo, r_win_hi;
    logic [31:0]     r_pass;
    logic [SW-1:0]   r_set_cnt;
    logic [TW-1:0]   r_to_cnt;
    logic [7:0]      r_good;
    logic [2:0]      r_pre;
    logic            r_dv_q, r_fail;
    logic [4:0]      r_idx, r_cur_st, r_best_st;
    logic [5:0]      r_cur_len, r_best_len;

    logic w_start, w_edge, w_timeout, w_settled;
    logic w_is_pre, w_is_sfd, w_hunt_ok, w_hunt_bad;
    logic w_frm_good, w_frm_bad, w_good_last;
    logic w_tap_pass, w_tap_fail, w_busy, w_done;
    logic w_bit, w_better, w_eval_end;
    logic [5:0] w_run_len, w_bl, w_sum;
    logic [4:0] w_run_st, w_bs, w_hi;

`ifdef RGMII_RX_DLY_CAL_AUTO_START_EN
    logic r_auto;
    always_ff @(posedge gmii_rx_clk or negedge rst_n) begin
        if (!rst_n) r_auto <= 1'b1;
        else        r_auto <= 1'b0;
    end
    assign w_start = bus.cal_start | r_auto;
`else
    assign w_start = bus.cal_start;
`endif

    assign w_edge      = bus.gmii_rx_dv & ~r_dv_q;
    assign w_timeout   = (r_to_cnt == TW'(TIMEOUT_CYC - 1));
    assign w_settled   = (r_set_cnt == SW'(SETTLE_CYC - 1));
    assign w_is_pre    = (bus.gmii_rxd == PRE);
    assign w_is_sfd    = (bus.gmii_rxd == SFD);
    assign w_hunt_ok   = w_edge & w_is_pre;
    assign w_hunt_bad  = w_edge & ~w_is_pre;
    assign w_frm_good  = bus.gmii_rx_dv & w_is_sfd;
    assign w_frm_bad   = ~bus.gmii_rx_dv
                       | (~w_is_pre & ~w_is_sfd)
                       | (w_is_pre & (r_pre == 3'd7));
    assign w_good_last = (r_good == 8'(FRAMES_PER_TAP - 1));

    // Run tracker: strict '>' keeps the lowest-index run on a tie
    assign w_bit      = r_pass[r_idx];
    assign w_run_len  = w_bit ? r_cur_len + 6'd1 : 6'd0;
    assign w_run_st   = (r_cur_len == 6'd0) ? r_idx : r_cur_st;
    assign w_better   = (w_run_len > r_best_len);
    assign w_bl       = w_better ? w_run_len : r_best_len;
    assign w_bs       = w_better ? w_run_st : r_best_st;
    assign w_hi       = w_bs + 5'(w_bl - 6'd1);
    assign w_sum      = {1'b0, w_bs} + {1'b0, w_hi};
    assign w_eval_end = (r_idx == 5'd31);

    always_ff @(posedge gmii_rx_clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:    if (w_start) w_next = S_SET_TAP;
            S_SET_TAP: w_next = S_SETTLE;
            S_SETTLE:  if (w_settled) w_next = S_HUNT;
            S_HUNT: begin
                if (w_timeout || w_hunt_bad) w_next = S_NEXT;
                else if (w_hunt_ok)          w_next = S_CHECK;
            end
            S_CHECK: begin
                if (w_timeout || w_frm_bad) w_next = S_NEXT;
                else if (w_frm_good)        w_next = w_good_last ? S_NEXT : S_HUNT;
            end
            S_NEXT:    w_next = (r_tap == 5'd31) ? S_EVAL : S_SET_TAP;
            S_EVAL:    if (w_eval_end) w_next = S_DONE;
            S_DONE:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_busy     = (r_state != S_IDLE) && (r_state != S_DONE);
        w_done     = (r_state == S_DONE);
        w_tap_pass = (r_state == S_CHECK) && !w_timeout && !w_frm_bad
                   && w_frm_good && w_good_last;
        w_tap_fail = ((r_state == S_HUNT) && (w_timeout || w_hunt_bad))
                   || ((r_state == S_CHECK) && (w_timeout || w_frm_bad));
    end

    always_ff @(posedge gmii_rx_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dv_q     <= 1'b0;
            r_tap      <= 5'd0;
            r_in_dly   <= 5'(DEFAULT_TAP);
            r_pass     <= '0;
            r_set_cnt  <= '0;
            r_to_cnt   <= '0;
            r_good     <= 8'd0;
            r_pre      <= 3'd0;
            r_fail     <= 1'b0;
            r_win_lo   <= 5'd0;
            r_win_hi   <= 5'd0;
            r_idx      <= 5'd0;
            r_cur_st   <= 5'd0;
            r_best_st  <= 5'd0;
            r_cur_len  <= 6'd0;
            r_best_len <= 6'd0;
        end else begin
            r_dv_q <= bus.gmii_rx_dv;
            unique case (r_state)
                S_IDLE: if (w_start) begin
                    r_tap  <= 5'd0;
                    r_fail <= 1'b0;
                    r_pass <= '0;
                end
                S_SET_TAP: begin
                    r_in_dly  <= r_tap;
                    r_set_cnt <= '0;
                    r_to_cnt  <= '0;
                    r_good    <= 8'd0;
                end
                S_SETTLE: r_set_cnt <= r_set_cnt + 1'b1;
                S_HUNT: begin
                    r_to_cnt <= r_to_cnt + 1'b1;
                    r_pre    <= 3'd1;
                end
                S_CHECK: begin
                    r_to_cnt <= r_to_cnt + 1'b1;
                    if (w_is_pre) r_pre <= r_pre + 3'd1;
                    if (w_frm_good) r_good <= r_good + 8'd1;
                    if (w_tap_pass) r_pass[r_tap] <= 1'b1;
                end
                S_NEXT: begin
                    if (r_tap != 5'd31) r_tap <= r_tap + 5'd1;
                    r_idx      <= 5'd0;
                    r_cur_st   <= 5'd0;
                    r_best_st  <= 5'd0;
                    r_cur_len  <= 6'd0;
                    r_best_len <= 6'd0;
                end
                S_EVAL: begin
                    r_idx      <= r_idx + 5'd1;
                    r_cur_len  <= w_run_len;
                    r_cur_st   <= w_run_st;
                    r_best_len <= w_bl;
                    r_best_st  <= w_bs;
                    if (w_eval_end) begin
                        if (w_bl == 6'd0) begin
                            r_fail   <= 1'b1;
                            r_in_dly <= 5'(DEFAULT_TAP);
                            r_win_lo <= 5'd0;
                            r_win_hi <= 5'd0;
                        end else begin
                            r_win_lo <= w_bs;
                            r_win_hi <= w_hi;
                            r_in_dly <= w_sum[5:1];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_dly   = r_in_dly;
    assign bus.indly_en = 1'b1;
    assign bus.cal_busy = w_busy;
    assign bus.cal_done = w_done;
    assign bus.cal_fail = r_fail;
    assign bus.win_lo   = r_win_lo;
    assign bus.win_hi   = r_win_hi;
endmodule

// File: tb/tb_rgmii_rx_dly_cal.sv
// Bench for rgmii_rx_dly_cal: a channel model emits frames whose quality depends on in_dly.
module tb_rgmii_rx_dly_cal;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    int   done_cnt;
    int   mode;
    logic [31:0] mask;

    typedef struct {
        int          mode;
        logic [31:0] mask;
        logic [4:0]  lo;
        logic [4:0]  hi;
        logic [4:0]  dly;
        logic        fail;
    } vec_t;

    vec_t vt[6];

    rgmii_rx_dly_cal_if ifc ();

    rgmii_rx_dly_cal #(
        .FRAMES_PER_TAP (4),
        .SETTLE_CYC     (8),
        .TIMEOUT_CYC    (200),
        .DEFAULT_TAP    (7)
    ) dut (
        .gmii_rx_clk (clk),
        .rst_n       (rst_n),
        .bus         (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (ifc.cal_done === 1'b1) done_cnt++;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 ifc.cal_start = 1'b1;
        @(posedge clk); #1 ifc.cal_start = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (ifc.cal_done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        check({nm, "_done_seen"}, 32'(ok), 32'd1);
    endtask

    task automatic wait_dly(input logic [4:0] t);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (ifc.in_dly === t) begin
                ok = 1'b1;
                break;
            end
        end
        check("reach_tap", 32'(ok), 32'd1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
`ifdef RGMII_RX_DLY_CAL_AUTO_START_EN
        @(negedge clk);
        check("auto_start_busy", 32'(ifc.cal_busy), 32'd1);
        wait_done("auto");
`endif
    endtask

    // Channel model: frame content chosen at frame start from the live tap
    initial begin
        byte unsigned q[$];
        logic [4:0] tap;
        int gap;
        ifc.gmii_rx_dv = 1'b0;
        ifc.gmii_rxd   = 8'h00;
        forever begin
            q.delete();
            tap = ifc.in_dly;
            gap = 4;
            case (mode)
                1: begin
                    repeat (7) q.push_back(8'h55);
                    q.push_back(8'hD5);
                    q.push_back(8'h11); q.push_back(8'h22);
                    q.push_back(8'h33); q.push_back(8'h44);
                    if (!mask[tap]) q[3] = 8'h54;
                end
                2: begin
                    if (mask[tap]) begin
                        q.push_back(8'h55);
                        q.push_back(8'hD5);
                        repeat (4) q.push_back(8'hA0);
                    end else if (!tap[0]) begin
                        repeat (8) q.push_back(8'h55);
                        q.push_back(8'hD5);
                    end else begin
                        repeat (4) q.push_back(8'h55);
                    end
                end
                3: begin
                    repeat (7) q.push_back(8'h55);
                    q.push_back(8'hD5);
                    repeat (24) q.push_back(8'h00);
                    gap = 2;
                end
                default: gap = 1;
            endcase
            foreach (q[i]) begin
                @(posedge clk); #1;
                ifc.gmii_rx_dv = 1'b1;
                ifc.gmii_rxd   = q[i];
            end
            repeat (gap) begin
                @(posedge clk); #1;
                ifc.gmii_rx_dv = 1'b0;
                ifc.gmii_rxd   = 8'h00;
            end
        end
    end

    initial begin
        checks = 0; failures = 0; done_cnt = 0;
        mode = 0; mask = '0;
        rst_n = 1'b0;
        ifc.cal_start = 1'b0;

        vt[0] = '{1, 32'h001F_FC00, 5'd10, 5'd20, 5'd15, 1'b0};
        vt[1] = '{1, 32'h00F0_0078, 5'd3,  5'd6,  5'd4,  1'b0};
        vt[2] = '{0, 32'h0000_0000, 5'd0,  5'd0,  5'd7,  1'b1};
        vt[3] = '{2, 32'h0000_01E0, 5'd5,  5'd8,  5'd6,  1'b0};
        vt[4] = '{3, 32'hFFFF_FFFF, 5'd0,  5'd31, 5'd15, 1'b0};
        vt[5] = '{1, 32'h8000_0000, 5'd31, 5'd31, 5'd31, 1'b0};

        #12;
        check("rst_in_dly", 32'(ifc.in_dly), 32'd7);
        check("rst_indly_en", 32'(ifc.indly_en), 32'd1);
        check("rst_busy", 32'(ifc.cal_busy), 32'd0);
        check("rst_done", 32'(ifc.cal_done), 32'd0);
        check("rst_fail", 32'(ifc.cal_fail), 32'd0);
        check("rst_win", {ifc.win_lo, ifc.win_hi}, 32'd0);
        do_reset();

        // Re-pulsed cal_start mid-sweep must not restart the sweep
        mode = 1; mask = 32'h001F_FC00;
        done_cnt = 0;
        pulse_start();
        @(negedge clk);
        check("start_latency_busy", 32'(ifc.cal_busy), 32'd1);
        wait_dly(5'd12);
        pulse_start();
        repeat (20) @(negedge clk);
        check("repulse_no_restart", 32'(ifc.in_dly >= 5'd12), 32'd1);
        check("repulse_busy", 32'(ifc.cal_busy), 32'd1);
        wait_done("repulse");
        repeat (5) @(negedge clk);
        check("repulse_done_cnt", 32'(done_cnt), 32'd1);
        check("repulse_win_lo", 32'(ifc.win_lo), 32'd10);
        check("repulse_win_hi", 32'(ifc.win_hi), 32'd20);
        check("repulse_in_dly", 32'(ifc.in_dly), 32'd15);

        // Reset in the middle of the sweep
        done_cnt = 0;
        pulse_start();
        wait_dly(5'd12);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_in_dly", 32'(ifc.in_dly), 32'd7);
        check("midrst_busy", 32'(ifc.cal_busy), 32'd0);
        check("midrst_win", {ifc.win_lo, ifc.win_hi}, 32'd0);
        check("midrst_no_done", 32'(done_cnt), 32'd0);
        mode = 0;
        do_reset();
`ifndef RGMII_RX_DLY_CAL_AUTO_START_EN
        repeat (50) @(negedge clk);
        check("midrst_idle_done", 32'(done_cnt), 32'd0);
        check("midrst_idle_busy", 32'(ifc.cal_busy), 32'd0);
`endif

        for (int v = 0; v < 6; v++) begin
            mode = vt[v].mode;
            mask = vt[v].mask;
            repeat (40) @(negedge clk);
            done_cnt = 0;
            pulse_start();
            wait_done($sformatf("v%0d", v));
            repeat (5) @(negedge clk);
            check($sformatf("v%0d_done_cnt", v), 32'(done_cnt), 32'd1);
            check($sformatf("v%0d_win_lo", v), 32'(ifc.win_lo), 32'(vt[v].lo));
            check($sformatf("v%0d_win_hi", v), 32'(ifc.win_hi), 32'(vt[v].hi));
            check($sformatf("v%0d_in_dly", v), 32'(ifc.in_dly), 32'(vt[v].dly));
            check($sformatf("v%0d_fail", v), 32'(ifc.cal_fail), 32'(vt[v].fail));
            check($sformatf("v%0d_busy", v), 32'(ifc.cal_busy), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
